mms_esp_regfile_arbiter: RTL and testbench
==========================================

Name: mms_esp_regfile_arbiter

Overview:
- Synchronous arbiter for the 16-byte shared register file between the MMS16 I/O window (0x40–0x4F) and the ESP parallel link.
- Accepts one four-phase request per side, serialises accesses onto a single-port register file, and generates the MMS XACK timing.
- Maintains two doorbell flags that interrupt the opposite side.
- Bus polarity inversion and address-window decode happen outside the block; all signals here are true-polarity.

Parameters:
ADR_W, 4, register file address width
DAT_W, 8, register file data width
XACK_DELAY, 2, extra cycles inserted before MMS_ACK (0–7)
DB_TO_ESP, 4'hF, address whose MMS write raises ESP_IRQ
DB_TO_MMS, 4'hE, address whose ESP write raises MMS_IRQ

Ports:
MMS_BCLK  in  1  single clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
MMS_REQ  in  1  decoded IORC/IOWC cycle in window, held until MMS_ACK
MMS_WR  in  1  1=write, 0=read
MMS_ADR  in  ADR_W  register index
MMS_WDATA  in  DAT_W  write data
MMS_RDATA  out  DAT_W  registered read data, valid while MMS_ACK=1
MMS_ACK  out  1  drives XACK (external open-drain)
ESP_REQ/ESP_WR/ESP_ADR/ESP_WDATA  in  1/1/ADR_W/DAT_W  same semantics, ESP side
ESP_RDATA  out  DAT_W  registered read data
ESP_ACK  out  1  ESP access complete
RF_EN  out  1  register file access strobe
RF_WE  out  1  register file write enable
RF_ADR  out  ADR_W  register file address
RF_WDATA  out  DAT_W  register file write data
RF_RDATA  in  DAT_W  register file read data, 1-cycle latency after RF_EN
MMS_IRQ  out  1  doorbell to MMS (drives one MMS_INT line)
ESP_IRQ  out  1  doorbell to ESP
OWNER  out  2  debug: 00 idle, 01 MMS, 10 ESP

Behaviour:
- Reset (asynchronous, any state):
  - FSM returns to IDLE.
  - All outputs go to 0; RDATA registers clear to 0.
  - The last_owner register is set to ESP, so MMS wins the first tie.
- FSM states: IDLE, GRANT, CAPTURE, WAIT, ACK. The current owner is held in a register.
- IDLE:
  - If exactly one REQ is high, that side becomes owner.
  - If both REQs are high, the side that is not last_owner wins (round-robin).
  - The owner's WR/ADR/WDATA are latched; later changes to those inputs are ignored. Next state is GRANT.
- GRANT (1 cycle):
  - RF_EN=1; RF_WE, RF_ADR and RF_WDATA come from the latched request.
  - Doorbells update in this cycle (see below). Next state is CAPTURE.
- CAPTURE (1 cycle):
  - On a read, RF_RDATA is latched into the owner's RDATA register; the other side's RDATA is unchanged.
  - Next state is WAIT if owner=MMS and XACK_DELAY>0; otherwise ACK.
- WAIT: counts XACK_DELAY cycles, then goes to ACK. ESP never enters WAIT.
- ACK:
  - The owner's ACK is 1 and stays 1 until that side's REQ is sampled low.
  - Then ACK drops at the next edge, last_owner is set to the owner, and the FSM returns to IDLE.
  - Minimum of one IDLE cycle between accesses.
- Latency, with REQ first sampled high at edge k in IDLE and no contention:
  - MMS: ACK is high after edge k+3+XACK_DELAY.
  - ESP: ACK is high after edge k+3.
- Losing requester: keeps REQ high. It is granted on the first IDLE cycle after the current access, and is never starved (round-robin).
- REQ dropped before ACK (protocol violation): the access still completes and ACK is high for exactly one cycle.
- Doorbells (evaluated in GRANT):
  - MMS write to DB_TO_ESP sets ESP_IRQ; ESP read of DB_TO_ESP clears it.
  - ESP write to DB_TO_MMS sets MMS_IRQ; MMS read of DB_TO_MMS clears it.
  - Only one access occurs per GRANT, so set and clear never collide.
  - Doorbell addresses are still written to and read from the register file normally.
- OWNER: 00 in IDLE; otherwise reflects the current owner.

Test Plan:
- MMS write then read, XACK_DELAY=2: write 0xA5 to adr 3 -> RF_WE=1, RF_ADR=3, RF_WDATA=0xA5 in GRANT; MMS_ACK at k+5. Read adr 3 -> MMS_RDATA=0xA5 while ACK high.
- Simultaneous REQ after reset: both REQ high at the same edge -> MMS served first. ESP GRANT follows one IDLE cycle after MMS_REQ drops. A second simultaneous pair -> ESP served first.
- ESP latency: ESP read of adr 0 holding 0x3C -> ESP_ACK at k+3, ESP_RDATA=0x3C, MMS_RDATA unchanged.
- Doorbells: MMS writes 0x01 to adr F -> ESP_IRQ=1. ESP reads adr F -> ESP_IRQ=0, ESP_RDATA=0x01. ESP writes adr E -> MMS_IRQ=1. MMS reads adr E -> MMS_IRQ=0.
- Reset mid-operation: assert RESET while in WAIT -> MMS_ACK=0, RF_EN=0, both IRQs 0, OWNER=00 immediately (asynchronous). After release, a fresh MMS request completes normally.
- Early REQ drop: ESP_REQ deasserted during CAPTURE -> write still committed; ESP_ACK high for exactly 1 cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/mms_esp_regfile_arbiter_if.sv
// rtl/mms_esp_regfile_arbiter_if.sv - four-phase register file access port (one per requesting side)
//
// Purpose: groups one side's request/acknowledge handshake with its address and data.
// Signals:
//   REQ    requester -> arbiter  access request, held until ACK
//   WR     requester -> arbiter  1 = write, 0 = read
//   ADR    requester -> arbiter  register index
//   WDATA  requester -> arbiter  write data
//   RDATA  arbiter -> requester  read data, valid while ACK = 1
//   ACK    arbiter -> requester  access complete
// Modports: master = requesting side, slave = arbiter.
interface mms_esp_regfile_arbiter_if #(
  parameter int ADR_W = 4,
  parameter int DAT_W = 8
) ();
  logic             REQ;
  logic             WR;
  logic [ADR_W-1:0] ADR;
  logic [DAT_W-1:0] WDATA;
  logic [DAT_W-1:0] RDATA;
  logic             ACK;

  modport master (output REQ, output WR, output ADR, output WDATA,
                  input  RDATA, input ACK);
  modport slave  (input  REQ, input  WR, input  ADR, input  WDATA,
                  output RDATA, output ACK);
endinterface

// File: rtl/mms_esp_regfile_arbiter.sv
// rtl/mms_esp_regfile_arbiter.sv - MMS16/ESP arbiter for the shared 16-byte register file
//
// Purpose: serialises four-phase requests from the MMS I/O window and the ESP link onto a
// single-port register file, produces MMS XACK timing and keeps two cross-side doorbells.
// Ports:
//   MMS_BCLK  clock, all state on the rising edge
//   RESET     asynchronous active-high reset
//   mms, esp  requester ports (REQ/WR/ADR/WDATA in, RDATA/ACK out)
//   RF_EN/RF_WE/RF_ADR/RF_WDATA  register file strobe, write enable, address, write data
//   RF_RDATA  register file read data, one cycle after RF_EN
//   MMS_IRQ   doorbell to MMS (raised by an ESP write to DB_TO_MMS)
//   ESP_IRQ   doorbell to ESP (raised by an MMS write to DB_TO_ESP)
//   OWNER     debug: 00 idle, 01 MMS, 10 ESP
module mms_esp_regfile_arbiter #(
  parameter int               ADR_W      = 4,
  parameter int               DAT_W      = 8,
  parameter int               XACK_DELAY = 2,
  parameter logic [ADR_W-1:0] DB_TO_ESP  = '1,
  parameter logic [ADR_W-1:0] DB_TO_MMS  = {{(ADR_W-1){1'b1}}, 1'b0}
) (
  input  logic                     MMS_BCLK,
  input  logic                     RESET,
  mms_esp_regfile_arbiter_if.slave mms,
  mms_esp_regfile_arbiter_if.slave esp,
  output logic                     RF_EN,
  output logic                     RF_WE,
  output logic [ADR_W-1:0]         RF_ADR,
  output logic [DAT_W-1:0]         RF_WDATA,
  input  logic [DAT_W-1:0]         RF_RDATA,
  output logic                     MMS_IRQ,
  output logic                     ESP_IRQ,
  output logic [1:0]               OWNER
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_CAPTURE, S_WAIT, S_ACK} state_t;

  // WAIT holds for XACK_DELAY cycles: load delay-1 and leave when the counter reads zero.
  localparam logic [2:0] DLY_M1 = (XACK_DELAY > 0) ? 3'(XACK_DELAY - 1) : 3'd0;

  state_t             state_q, state_d;
  logic               owner_esp_q, owner_esp_d;   // 0 = MMS owns, 1 = ESP owns
  logic               last_esp_q, last_esp_d;     // side served last, loses the next tie
  logic               wr_q, wr_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   wdata_q, wdata_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic [DAT_W-1:0]   mms_rdata_q, mms_rdata_d;
  logic [DAT_W-1:0]   esp_rdata_q, esp_rdata_d;
  logic               mms_irq_q, mms_irq_d;
  logic               esp_irq_q, esp_irq_d;
  logic               pick_esp;
  logic               owner_req;

  always_ff @(posedge MMS_BCLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      owner_esp_q <= 1'b0;
      last_esp_q  <= 1'b1;
      wr_q        <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cnt_q       <= 3'd0;
      ack_q       <= 1'b0;
      mms_rdata_q <= '0;
      esp_rdata_q <= '0;
      mms_irq_q   <= 1'b0;
      esp_irq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_esp_q <= owner_esp_d;
      last_esp_q  <= last_esp_d;
      wr_q        <= wr_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      mms_rdata_q <= mms_rdata_d;
      esp_rdata_q <= esp_rdata_d;
      mms_irq_q   <= mms_irq_d;
      esp_irq_q   <= esp_irq_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_esp_d = owner_esp_q;
    last_esp_d  = last_esp_q;
    wr_d        = wr_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    ack_d       = ack_q;
    mms_rdata_d = mms_rdata_q;
    esp_rdata_d = esp_rdata_q;
    mms_irq_d   = mms_irq_q;
    esp_irq_d   = esp_irq_q;
    pick_esp    = 1'b0;
    owner_req   = owner_esp_q ? esp.REQ : mms.REQ;

    unique case (state_q)
      S_IDLE: begin
        if (mms.REQ || esp.REQ) begin
          // On a tie the side that was not served last wins.
          pick_esp    = esp.REQ && (!mms.REQ || !last_esp_q);
          owner_esp_d = pick_esp;
          wr_d        = pick_esp ? esp.WR    : mms.WR;
          adr_d       = pick_esp ? esp.ADR   : mms.ADR;
          wdata_d     = pick_esp ? esp.WDATA : mms.WDATA;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!owner_esp_q &&  wr_q && adr_q == DB_TO_ESP) esp_irq_d = 1'b1;
        if ( owner_esp_q && !wr_q && adr_q == DB_TO_ESP) esp_irq_d = 1'b0;
        if ( owner_esp_q &&  wr_q && adr_q == DB_TO_MMS) mms_irq_d = 1'b1;
        if (!owner_esp_q && !wr_q && adr_q == DB_TO_MMS) mms_irq_d = 1'b0;
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!wr_q) begin
          if (owner_esp_q) esp_rdata_d = RF_RDATA;
          else             mms_rdata_d = RF_RDATA;
        end
        if (!owner_esp_q && XACK_DELAY > 0) begin
          cnt_d   = DLY_M1;
          state_d = S_WAIT;
        end else begin
          state_d = S_ACK;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) state_d = S_ACK;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_ACK: begin
        // ACK is registered: it rises one edge after entering ACK and is held until the
        // owner's REQ is seen low while ACK is up, so an early-dropped REQ still gets
        // exactly one ACK cycle.
        if (ack_q && !owner_req) begin
          ack_d      = 1'b0;
          last_esp_d = owner_esp_q;
          state_d    = S_IDLE;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RF_EN     = (state_q == S_GRANT);
  assign RF_WE     = RF_EN && wr_q;
  assign RF_ADR    = adr_q;
  assign RF_WDATA  = wdata_q;
  assign mms.ACK   = ack_q && !owner_esp_q;
  assign esp.ACK   = ack_q &&  owner_esp_q;
  assign mms.RDATA = mms_rdata_q;
  assign esp.RDATA = esp_rdata_q;
  assign MMS_IRQ   = mms_irq_q;
  assign ESP_IRQ   = esp_irq_q;
  assign OWNER     = (state_q == S_IDLE) ? 2'b00 : (owner_esp_q ? 2'b10 : 2'b01);

endmodule

// File: tb/tb_mms_esp_regfile_arbiter.sv
// tb/tb_mms_esp_regfile_arbiter.sv - directed scoreboard bench for mms_esp_regfile_arbiter
module tb_mms_esp_regfile_arbiter;

  localparam int MMS_LAT = 6;   // k+3+XACK_DELAY with XACK_DELAY=2, counting edge k as 1
  localparam int ESP_LAT = 4;   // k+3

  logic       clk = 1'b0;
  logic       rst;
  logic       rf_en, rf_we;
  logic [3:0] rf_adr;
  logic [7:0] rf_wdata, rf_rdata;
  logic       mms_irq, esp_irq;
  logic [1:0] owner;

  always #5 clk = ~clk;

  mms_esp_regfile_arbiter_if #(.ADR_W(4), .DAT_W(8)) mms_if ();
  mms_esp_regfile_arbiter_if #(.ADR_W(4), .DAT_W(8)) esp_if ();

  mms_esp_regfile_arbiter #(
    .ADR_W(4), .DAT_W(8), .XACK_DELAY(2), .DB_TO_ESP(4'hF), .DB_TO_MMS(4'hE)
  ) dut (
    .MMS_BCLK (clk),
    .RESET    (rst),
    .mms      (mms_if),
    .esp      (esp_if),
    .RF_EN    (rf_en),
    .RF_WE    (rf_we),
    .RF_ADR   (rf_adr),
    .RF_WDATA (rf_wdata),
    .RF_RDATA (rf_rdata),
    .MMS_IRQ  (mms_irq),
    .ESP_IRQ  (esp_irq),
    .OWNER    (owner)
  );

  // Single-port register file with one-cycle read latency.
  logic [7:0] rf_mem [16];
  always @(posedge clk) begin
    if (rf_en) begin
      if (rf_we) rf_mem[rf_adr] <= rf_wdata;
      rf_rdata <= rf_mem[rf_adr];
    end
  end

  typedef struct {
    logic       rd;
    logic [7:0] data;
  } exp_t;

  exp_t       mms_q[$];
  exp_t       esp_q[$];
  logic [7:0] model_mem [16];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic       g_en, g_we;
  logic [1:0] g_owner;
  logic [3:0] g_adr;
  logic [7:0] g_wdata;
  int         lat;
  int         hi;
  exp_t       dropped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic ack_of(input int side);
    return (side == 0) ? mms_if.ACK : esp_if.ACK;
  endfunction

  task automatic start(input int side, input logic wr, input logic [3:0] adr, input logic [7:0] wd);
    exp_t e;
    e.rd   = !wr;
    e.data = wr ? 8'h00 : model_mem[adr];
    if (wr) model_mem[adr] = wd;
    if (side == 0) begin
      mms_if.WR = wr; mms_if.ADR = adr; mms_if.WDATA = wd; mms_if.REQ = 1'b1;
      mms_q.push_back(e);
    end else begin
      esp_if.WR = wr; esp_if.ADR = adr; esp_if.WDATA = wd; esp_if.REQ = 1'b1;
      esp_q.push_back(e);
    end
  endtask

  // Counts edges from the first IDLE edge that samples REQ; the first edge is the GRANT entry.
  task automatic wait_ack(input int side, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        g_en = rf_en; g_we = rf_we; g_owner = owner; g_adr = rf_adr; g_wdata = rf_wdata;
      end
      if (ack_of(side)) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check("ack_timeout", 32'(ack_of(side)), 32'd1);
  endtask

  task automatic finish(input int side, input string tag);
    exp_t       e;
    logic [7:0] rd;
    e.rd = 1'b0; e.data = 8'h00;
    rd = (side == 0) ? mms_if.RDATA : esp_if.RDATA;
    if (side == 0 && mms_q.size() > 0) e = mms_q.pop_front();
    if (side == 1 && esp_q.size() > 0) e = esp_q.pop_front();
    if (e.rd) check({tag, "_rdata"}, 32'(rd), 32'(e.data));
    if (side == 0) mms_if.REQ = 1'b0; else esp_if.REQ = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ack_drop"}, 32'(ack_of(side)), 32'd0);
    check({tag, "_owner_idle"}, 32'(owner), 32'd0);
  endtask

  task automatic access(input int side, input logic wr, input logic [3:0] adr,
                        input logic [7:0] wd, input int exp_lat, input string tag);
    int c;
    start(side, wr, adr, wd);
    wait_ack(side, c);
    check({tag, "_lat"}, 32'(c), 32'(exp_lat));
    finish(side, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mms_if.REQ = 1'b0; mms_if.WR = 1'b0; mms_if.ADR = 4'h0; mms_if.WDATA = 8'h00;
    esp_if.REQ = 1'b0; esp_if.WR = 1'b0; esp_if.ADR = 4'h0; esp_if.WDATA = 8'h00;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mms_ack",   32'(mms_if.ACK),   32'd0);
    check("rst_esp_ack",   32'(esp_if.ACK),   32'd0);
    check("rst_rf_en",     32'(rf_en),        32'd0);
    check("rst_irqs",      32'({mms_irq, esp_irq}), 32'd0);
    check("rst_owner",     32'(owner),        32'd0);
    check("rst_mms_rdata", 32'(mms_if.RDATA), 32'd0);
    check("rst_esp_rdata", 32'(esp_if.RDATA), 32'd0);
    rst = 1'b0;

    // Simultaneous requests after reset: MMS first, ESP after one IDLE cycle
    start(0, 1'b1, 4'h1, 8'h22);
    start(1, 1'b1, 4'h2, 8'h33);
    wait_ack(0, lat);
    check("pair1_mms_owner", 32'(g_owner), 32'd1);
    check("pair1_mms_lat",   32'(lat),     32'(MMS_LAT));
    finish(0, "pair1_mms");
    wait_ack(1, lat);
    check("pair1_esp_grant", 32'({g_en, g_owner}), 32'({1'b1, 2'b10}));
    check("pair1_esp_lat",   32'(lat),     32'(ESP_LAT));
    finish(1, "pair1_esp");

    // MMS write 0xA5 to adr 3 with GRANT-cycle register file checks, then read back
    start(0, 1'b1, 4'h3, 8'hA5);
    wait_ack(0, lat);
    check("mwr_rf_en",    32'(g_en),    32'd1);
    check("mwr_rf_we",    32'(g_we),    32'd1);
    check("mwr_rf_adr",   32'(g_adr),   32'h3);
    check("mwr_rf_wdata", 32'(g_wdata), 32'hA5);
    check("mwr_lat",      32'(lat),     32'(MMS_LAT));
    finish(0, "mwr");
    access(0, 1'b0, 4'h3, 8'h00, MMS_LAT, "mrd");

    // Second simultaneous pair: MMS was served last, so ESP wins
    start(0, 1'b0, 4'h2, 8'h00);
    start(1, 1'b0, 4'h1, 8'h00);
    wait_ack(1, lat);
    check("pair2_esp_owner", 32'(g_owner), 32'd2);
    check("pair2_esp_lat",   32'(lat),     32'(ESP_LAT));
    finish(1, "pair2_esp");
    wait_ack(0, lat);
    check("pair2_mms_owner", 32'(g_owner), 32'd1);
    check("pair2_mms_lat",   32'(lat),     32'(MMS_LAT));
    finish(0, "pair2_mms");

    // ESP latency and RDATA isolation (MMS_RDATA keeps 0x33 from the pair2 read)
    access(1, 1'b1, 4'h0, 8'h3C, ESP_LAT, "ewr0");
    access(1, 1'b0, 4'h0, 8'h00, ESP_LAT, "erd0");
    check("erd0_mms_rdata_kept", 32'(mms_if.RDATA), 32'h33);

    // Doorbells
    access(0, 1'b1, 4'hF, 8'h01, MMS_LAT, "db_mwrF");
    check("db_esp_irq_set",   32'({mms_irq, esp_irq}), 32'b01);
    access(1, 1'b0, 4'hF, 8'h00, ESP_LAT, "db_erdF");
    check("db_esp_irq_clr",   32'(esp_irq), 32'd0);
    access(1, 1'b1, 4'hE, 8'h5A, ESP_LAT, "db_ewrE");
    check("db_mms_irq_set",   32'({mms_irq, esp_irq}), 32'b10);
    access(0, 1'b0, 4'hE, 8'h00, MMS_LAT, "db_mrdE");
    check("db_mms_irq_clr",   32'(mms_irq), 32'd0);

    // ESP drops REQ during CAPTURE: write commits, ACK high exactly one cycle
    start(1, 1'b1, 4'h7, 8'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    esp_if.REQ = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (esp_if.ACK) hi++;
    end
    check("drop_ack_cycles", 32'(hi),    32'd1);
    check("drop_owner_idle", 32'(owner), 32'd0);
    if (esp_q.size() > 0) dropped = esp_q.pop_front();
    access(0, 1'b0, 4'h7, 8'h00, MMS_LAT, "drop_commit");

    // Reset while MMS access sits in WAIT (its GRANT already raised ESP_IRQ)
    start(0, 1'b1, 4'hF, 8'h02);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_pre_irq_owner", 32'({esp_irq, owner}), 32'({1'b1, 2'b01}));
    rst = 1'b1;
    #1;
    check("mid_mms_ack",   32'(mms_if.ACK),   32'd0);
    check("mid_rf_en",     32'(rf_en),        32'd0);
    check("mid_irqs",      32'({mms_irq, esp_irq}), 32'd0);
    check("mid_owner",     32'(owner),        32'd0);
    check("mid_mms_rdata", 32'(mms_if.RDATA), 32'd0);
    @(posedge clk); #1;
    mms_if.REQ = 1'b0;
    mms_q.delete();
    rst = 1'b0;
    access(0, 1'b0, 4'hF, 8'h00, MMS_LAT, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
